// File: rtl/measurement_stream_sender_pkg.sv
// Shared constants for the host-to-controller measurement byte stream.
// Holds the message codes, the sender state encoding and a byte-count helper.
package measurement_stream_sender_pkg;

    localparam logic [7:0] START_DECODING_MSG      = 8'h01;
    localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_SEND_START  = 3'd1;
    localparam logic [2:0] ST_SEND_HEADER = 3'd2;
    localparam logic [2:0] ST_LOAD_ROUND  = 3'd3;
    localparam logic [2:0] ST_SEND_ROUND  = 3'd4;
    localparam logic [2:0] ST_WAIT_RESULT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE        = ST_IDLE,
        S_SEND_START  = ST_SEND_START,
        S_SEND_HEADER = ST_SEND_HEADER,
        S_LOAD_ROUND  = ST_LOAD_ROUND,
        S_SEND_ROUND  = ST_SEND_ROUND,
        S_WAIT_RESULT = ST_WAIT_RESULT
    } sender_state_e;

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/measurement_stream_sender_if.sv
// Byte stream from the sender to the controller's input port.
interface measurement_stream_sender_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/measurement_stream_sender_byte_serializer.sv
// Round buffer and byte output stage: emits the latched round LSB-first and
// muxes in the control bytes (start / header) supplied by the sequencer.
module measurement_stream_sender_byte_serializer
    import measurement_stream_sender_pkg::*;
#(
    parameter int PU_COUNT        = 6,
    parameter int BYTES_PER_ROUND = bytes_for(PU_COUNT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [PU_COUNT-1:0] i_round_data,
    input  logic                i_round_active,
    input  logic                i_ctrl_valid,
    input  logic [7:0]          i_ctrl_byte,
    output logic                o_last_done,
    measurement_stream_sender_if.master tx
);

    localparam int BUF_W = BYTES_PER_ROUND * 8;
    localparam int CNT_W = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_ROUND - 1);

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [BUF_W-1:0] w_shifted;
    logic             w_xfer;

    assign w_shifted   = r_buf >> {r_byte_cnt, 3'b000};
    assign w_xfer      = i_round_active & tx.tx_ready;
    assign o_last_done = w_xfer & (r_byte_cnt == LAST_IDX);

    assign tx.tx_valid = i_round_active | i_ctrl_valid;
    assign tx.tx_data  = i_round_active ? w_shifted[7:0] : i_ctrl_byte;

    // Counter returns to 0 after the last byte so it never indexes past the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf      <= '0;
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_buf      <= BUF_W'(i_round_data);
            r_byte_cnt <= '0;
        end else if (o_last_done) begin
            r_byte_cnt <= '0;
        end else if (w_xfer) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/measurement_stream_sender.sv
// Host-side sender: START message on command, or header plus GRID_WIDTH_U
// packed rounds, then waits for the controller result and reports latency.
module measurement_stream_sender
    import measurement_stream_sender_pkg::*;
#(
    parameter int GRID_WIDTH_X   = 3,
    parameter int GRID_WIDTH_Z   = 2,
    parameter int GRID_WIDTH_U   = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 i_start_cmd,
    input  logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0] i_round_data,
    input  logic                                 i_round_valid,
    output logic                                 o_round_ready,
    measurement_stream_sender_if.master          tx,
    input  logic                                 i_result_valid,
    output logic                                 o_busy,
    output logic [31:0]                          o_latency,
    output logic                                 o_latency_valid,
    output logic                                 o_timeout_err
);

    localparam int PU_COUNT_PER_ROUND = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int BYTES_PER_ROUND    = bytes_for(PU_COUNT_PER_ROUND);
    localparam int RC_W               = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
    localparam logic [RC_W-1:0] LAST_ROUND = RC_W'(GRID_WIDTH_U - 1);
    localparam logic [31:0]     TIMEOUT    = 32'(TIMEOUT_CYCLES);

    sender_state_e r_state;
    sender_state_e w_state_next;

    logic [RC_W-1:0] r_round_cnt;
    logic [31:0]     r_wait_cnt;
    logic [31:0]     w_wait_inc;
    logic [31:0]     r_latency;
    logic            r_latency_valid;
    logic            r_timeout_err;

    logic            w_load;
    logic            w_round_active;
    logic            w_ctrl_valid;
    logic [7:0]      w_ctrl_byte;
    logic            w_last_done;
    logic            w_result_hit;
    logic            w_timeout_hit;
    logic            w_clr_err;

    assign w_wait_inc     = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 32'd1;
    assign w_round_active = (r_state == S_SEND_ROUND);
    assign w_ctrl_valid   = (r_state == S_SEND_START) | (r_state == S_SEND_HEADER);
    assign w_ctrl_byte    = (r_state == S_SEND_START)  ? START_DECODING_MSG :
                            (r_state == S_SEND_HEADER) ? MEASUREMENT_DATA_HEADER : 8'h00;
    assign o_round_ready  = (r_state == S_LOAD_ROUND);
    assign w_load         = o_round_ready & i_round_valid;

    assign o_busy          = (r_state != S_IDLE);
    assign o_latency       = r_latency;
    assign o_latency_valid = r_latency_valid;
    assign o_timeout_err   = r_timeout_err;

    measurement_stream_sender_byte_serializer #(
        .PU_COUNT        (PU_COUNT_PER_ROUND),
        .BYTES_PER_ROUND (BYTES_PER_ROUND)
    ) u_serializer (
        .clk            (clk),
        .rst_n          (reset_n),
        .i_load         (w_load),
        .i_round_data   (i_round_data),
        .i_round_active (w_round_active),
        .i_ctrl_valid   (w_ctrl_valid),
        .i_ctrl_byte    (w_ctrl_byte),
        .o_last_done    (w_last_done),
        .tx             (tx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_result_hit  = 1'b0;
        w_timeout_hit = 1'b0;
        w_clr_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start_cmd) begin
                    w_state_next = S_SEND_START;
                    w_clr_err    = 1'b1;
                end else if (i_round_valid) begin
                    w_state_next = S_SEND_HEADER;
                end
            end
            S_SEND_START: if (tx.tx_ready) w_state_next = S_IDLE;
            S_SEND_HEADER: if (tx.tx_ready) w_state_next = S_LOAD_ROUND;
            S_LOAD_ROUND: begin
                if (i_round_valid) begin
                    w_state_next = S_SEND_ROUND;
                    w_clr_err    = 1'b1;
                end
            end
            S_SEND_ROUND: begin
                if (w_last_done)
                    w_state_next = (r_round_cnt == LAST_ROUND) ? S_WAIT_RESULT : S_LOAD_ROUND;
            end
            S_WAIT_RESULT: begin
                // A result arriving on the timeout cycle still counts as a result.
                if (i_result_valid) begin
                    w_result_hit = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_wait_inc >= TIMEOUT) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_round_cnt     <= '0;
            r_wait_cnt      <= '0;
            r_latency       <= '0;
            r_latency_valid <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_latency_valid <= 1'b0;
            if (w_clr_err)     r_timeout_err <= 1'b0;
            if (w_timeout_hit) r_timeout_err <= 1'b1;
            if (w_result_hit) begin
                r_latency       <= w_wait_inc;
                r_latency_valid <= 1'b1;
            end
            r_wait_cnt <= (r_state == S_WAIT_RESULT) ? w_wait_inc : 32'd0;
            if (w_state_next == S_IDLE)
                r_round_cnt <= '0;
            else if (w_last_done && (r_round_cnt != LAST_ROUND))
                r_round_cnt <= r_round_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_measurement_stream_sender.sv
// Directed bench: a 6-PU/3-round sender and a 12-PU/1-round sender with a
// short timeout, both fed from hand-written vectors.
module tb_measurement_stream_sender;

    localparam logic [7:0] START = 8'h01;
    localparam logic [7:0] HDR   = 8'h02;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, rv_a, res_a, rr_a, busy_a, lv_a, to_a;
    logic [5:0]  rd_a;
    logic [31:0] lat_a;
    logic        start_b, rv_b, res_b, rr_b, busy_b, lv_b, to_b;
    logic [11:0] rd_b;
    logic [31:0] lat_b;

    int n_run  = 0;
    int n_fail = 0;
    int viol   = 0;
    bit stall_a = 1'b0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    bit         st_a = 1'b0, st_b = 1'b0;
    logic [7:0] pd_a, pd_b;

    measurement_stream_sender_if if_a();
    measurement_stream_sender_if if_b();

    measurement_stream_sender #(
        .GRID_WIDTH_X(3), .GRID_WIDTH_Z(2), .GRID_WIDTH_U(3), .TIMEOUT_CYCLES(64)
    ) dut_a (
        .clk(clk), .reset_n(rst_n), .i_start_cmd(start_a), .i_round_data(rd_a),
        .i_round_valid(rv_a), .o_round_ready(rr_a), .tx(if_a), .i_result_valid(res_a),
        .o_busy(busy_a), .o_latency(lat_a), .o_latency_valid(lv_a), .o_timeout_err(to_a)
    );

    measurement_stream_sender #(
        .GRID_WIDTH_X(4), .GRID_WIDTH_Z(3), .GRID_WIDTH_U(1), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk), .reset_n(rst_n), .i_start_cmd(start_b), .i_round_data(rd_b),
        .i_round_valid(rv_b), .o_round_ready(rr_b), .tx(if_b), .i_result_valid(res_b),
        .o_busy(busy_b), .o_latency(lat_b), .o_latency_valid(lv_b), .o_timeout_err(to_b)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so a transfer seen here lands on the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            st_a = 1'b0;
            st_b = 1'b0;
        end else begin
            if (st_a && !(if_a.tx_valid && if_a.tx_data == pd_a)) viol++;
            if (st_b && !(if_b.tx_valid && if_b.tx_data == pd_b)) viol++;
            st_a = if_a.tx_valid && !if_a.tx_ready;
            st_b = if_b.tx_valid && !if_b.tx_ready;
            pd_a = if_a.tx_data;
            pd_b = if_b.tx_data;
            if (if_a.tx_valid && if_a.tx_ready) q_a.push_back(if_a.tx_data);
            if (if_b.tx_valid && if_b.tx_ready) q_b.push_back(if_b.tx_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_a) if_a.tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_round(input bit sel, input logic [11:0] d, input string tag);
        int ok = 0;
        if (sel) begin rd_b = d; rv_b = 1'b1; end
        else     begin rd_a = d[5:0]; rv_a = 1'b1; end
        for (int i = 0; i < 300; i++) begin
            if (sel ? rr_b : rr_a) begin ok = 1; break; end
            tick();
        end
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        tick();
        rv_a = 1'b0;
        rv_b = 1'b0;
    endtask

    task automatic wait_tx_idle(input bit sel, input string tag);
        int ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (!(sel ? if_b.tx_valid : if_a.tx_valid)) begin ok = 1; break; end
            tick();
        end
        chk({tag, "_drain"}, 32'(ok), 32'd1);
    endtask

    task automatic expect_stream(input string tag, input logic [7:0] got[$], input int n,
                                 input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                 input logic [7:0] e3, input logic [7:0] e4);
        logic [7:0] e[5];
        e = '{e0, e1, e2, e3, e4};
        chk({tag, "_len"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(e[i]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; rv_a = 1'b0; res_a = 1'b0; rd_a = '0;
        start_b = 1'b0; rv_b = 1'b0; res_b = 1'b0; rd_b = '0;
        if_a.tx_ready = 1'b1;
        if_b.tx_ready = 1'b1;
        #3;
        chk("rst_txv_a",  32'(if_a.tx_valid), 32'd0);
        chk("rst_txd_a",  32'(if_a.tx_data),  32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_rr_a",   32'(rr_a),   32'd0);
        chk("rst_lat_a",  lat_a,       32'd0);
        chk("rst_lv_a",   32'(lv_a),   32'd0);
        chk("rst_to_a",   32'(to_a),   32'd0);
        chk("rst_txv_b",  32'(if_b.tx_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // three rounds, no stall, result 17 cycles after the last byte
        send_round(0, 12'h02D, "t1r0");
        send_round(0, 12'h000, "t1r1");
        send_round(0, 12'h03F, "t1r2");
        repeat (17) tick();
        chk("t1_txv_low", 32'(if_a.tx_valid), 32'd0);
        chk("t1_busy",    32'(busy_a), 32'd1);
        expect_stream("t1", q_a, 4, HDR, 8'h2D, 8'h00, 8'h3F, 8'h00);
        res_a = 1'b1;
        tick();
        res_a = 1'b0;
        chk("t1_lv",        32'(lv_a), 32'd1);
        chk("t1_latency",   lat_a,     32'd17);
        chk("t1_busy_fall", 32'(busy_a), 32'd0);
        tick();
        chk("t1_lv_pulse",  32'(lv_a), 32'd0);

        // same rounds with random back-pressure; result on the first waiting cycle
        q_a.delete();
        stall_a = 1'b1;
        send_round(0, 12'h02D, "t2r0");
        send_round(0, 12'h000, "t2r1");
        send_round(0, 12'h03F, "t2r2");
        wait_tx_idle(0, "t2");
        stall_a = 1'b0;
        if_a.tx_ready = 1'b1;
        res_a = 1'b1;
        tick();
        res_a = 1'b0;
        chk("t2_lv",      32'(lv_a), 32'd1);
        chk("t2_latency", lat_a,     32'd1);
        expect_stream("t2", q_a, 4, HDR, 8'h2D, 8'h00, 8'h3F, 8'h00);

        // start_cmd and round_valid together: START first, round held until LOAD_ROUND
        q_a.delete();
        start_a = 1'b1; rd_a = 6'h15; rv_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("t3_rr_during_start", 32'(rr_a), 32'd0);
        chk("t3_start_byte",      32'(if_a.tx_data), 32'(START));
        send_round(0, 12'h015, "t3r0");
        expect_stream("t3_pre", q_a, 2, START, HDR, 8'h00, 8'h00, 8'h00);
        send_round(0, 12'h02A, "t3r1");
        send_round(0, 12'h011, "t3r2");
        wait_tx_idle(0, "t3");
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        res_a = 1'b1;
        tick();
        res_a = 1'b0;
        chk("t3_lv",      32'(lv_a), 32'd1);
        chk("t3_latency", lat_a,     32'd5);
        chk("t3_to",      32'(to_a), 32'd0);
        expect_stream("t3", q_a, 5, START, HDR, 8'h15, 8'h2A, 8'h11);

        // 12-PU round, LSB byte first, then timeout with no result
        send_round(1, 12'hA5C, "t4");
        wait_tx_idle(1, "t4");
        expect_stream("t4", q_b, 3, HDR, 8'h5C, 8'h0A, 8'h00, 8'h00);
        repeat (15) tick();
        chk("t4_to_early", 32'(to_b),   32'd0);
        chk("t4_busy",     32'(busy_b), 32'd1);
        tick();
        chk("t4_timeout",  32'(to_b),   32'd1);
        chk("t4_idle",     32'(busy_b), 32'd0);
        chk("t4_no_lv",    32'(lv_b),   32'd0);
        res_b = 1'b1;
        tick();
        res_b = 1'b0;
        chk("t4_res_ignored", 32'(lv_b), 32'd0);

        // result on the timeout cycle wins; accepted round clears the sticky error
        q_b.delete();
        send_round(1, 12'h123, "t5");
        chk("t5_to_cleared", 32'(to_b), 32'd0);
        wait_tx_idle(1, "t5");
        repeat (15) tick();
        res_b = 1'b1;
        tick();
        res_b = 1'b0;
        chk("t5_lv",      32'(lv_b), 32'd1);
        chk("t5_latency", lat_b,     32'd16);
        chk("t5_to",      32'(to_b), 32'd0);
        expect_stream("t5", q_b, 3, HDR, 8'h23, 8'h01, 8'h00, 8'h00);

        // reset while the second data byte is stalled
        q_b.delete();
        send_round(1, 12'hFFF, "t6");
        tick();
        if_b.tx_ready = 1'b0;
        chk("t6_byte1",  32'(if_b.tx_data),  32'h0F);
        chk("t6_valid1", 32'(if_b.tx_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_txv", 32'(if_b.tx_valid), 32'd0);
        chk("t6_async_busy", 32'(busy_b), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        if_b.tx_ready = 1'b1;
        q_b.delete();
        send_round(1, 12'h0B7, "t6r");
        wait_tx_idle(1, "t6r");
        expect_stream("t6r", q_b, 3, HDR, 8'hB7, 8'h00, 8'h00, 8'h00);
        res_b = 1'b1;
        tick();
        res_b = 1'b0;
        chk("t6_lv",      32'(lv_b), 32'd1);
        chk("t6_latency", lat_b,     32'd1);

        chk("stall_hold", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/measurement_stream_sender.md
Name: measurement_stream_sender

Overview:
- Host-side transmitter for the decoder control byte stream. It drives the `input_data`/`input_valid`/`input_ready` port of the single-FPGA unified controller.
- Serializes GRID_WIDTH_U rounds of per-round measurement vectors as a MEASUREMENT_DATA_HEADER byte followed by packed measurement bytes. It also sends START_DECODING_MSG on command.
- After the last byte it waits for the controller's result pulse and reports decode latency.
- Used in the FPGA test harness and as the front end of the host link.

Parameters:
- GRID_WIDTH_X, 3, PU columns per round.
- GRID_WIDTH_Z, 2, PU rows per round.
- GRID_WIDTH_U, 3, measurement rounds per decode.
- TIMEOUT_CYCLES, 4096, maximum wait for the result before the error flag is raised.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start_cmd  in  1  single-cycle request to send START_DECODING_MSG.
- round_data  in  PU_COUNT_PER_ROUND  one round of measurements; bit i = PU i.
- round_valid  in  1  round_data valid.
- round_ready  out  1  round accepted when round_valid && round_ready.
- tx_data  out  8  byte to controller.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  controller ready; a byte transfers when tx_valid && tx_ready.
- result_valid  in  1  controller result pulse.
- busy  out  1  high from the first byte until DONE or error.
- latency  out  32  cycles from the last-byte transfer to result_valid; saturates at 2^32-1.
- latency_valid  out  1  one-cycle pulse when latency is updated.
- timeout_err  out  1  sticky; cleared by the next accepted start_cmd or round.

Behaviour:
- Derived constants: PU_COUNT_PER_ROUND = X*Z; BYTES_PER_ROUND = ceil(PU_COUNT_PER_ROUND/8); the byte buffer is BYTES_PER_ROUND*8 bits, zero-padded above PU_COUNT_PER_ROUND.
- Reset values: all outputs 0, state IDLE, counters 0, buffer 0.
- Reset asserted mid-operation aborts immediately: tx_valid drops asynchronously and no partial stream resumes.
- States:
  - IDLE
  - SEND_START
  - SEND_HEADER
  - LOAD_ROUND
  - SEND_ROUND
  - WAIT_RESULT
- IDLE:
  - start_cmd has priority over round_valid in the same cycle: go to SEND_START; the round stays pending and is not accepted.
  - Otherwise, round_valid goes to SEND_HEADER. The round is not yet accepted; round_ready stays 0 in IDLE.
- SEND_START: tx_data = START_DECODING_MSG, tx_valid = 1. On transfer, go to IDLE.
- SEND_HEADER: tx_data = MEASUREMENT_DATA_HEADER. On transfer, go to LOAD_ROUND.
  - The header is sent once per decode, not per round.
- LOAD_ROUND:
  - round_ready = 1 combinationally.
  - On handshake: latch round_data into the buffer, clear byte_cnt, go to SEND_ROUND.
- SEND_ROUND:
  - tx_data = buffer[8*byte_cnt+7 : 8*byte_cnt]; the least significant byte goes first, matching the controller's shift-down packing.
  - On each transfer, byte_cnt increments.
  - On the transfer with byte_cnt == BYTES_PER_ROUND-1, increment round_cnt.
    - If round_cnt == GRID_WIDTH_U-1: go to WAIT_RESULT, clear wait_cnt.
    - Otherwise: go to LOAD_ROUND.
- Stream contract:
  - tx_valid, once asserted, stays high with tx_data stable until the transfer. No bubble is inserted by the sender itself.
  - tx_valid = 1 only in SEND_START, SEND_HEADER and SEND_ROUND.
- WAIT_RESULT:
  - wait_cnt increments each cycle (saturating). The first cycle after the last transfer counts 1.
  - On result_valid: latency <= wait_cnt, latency_valid pulses, go to IDLE, busy falls.
  - If wait_cnt reaches TIMEOUT_CYCLES first: timeout_err <= 1, go to IDLE.
  - result_valid and the timeout in the same cycle: the result wins and timeout_err is not set.
- result_valid in any other state is ignored.
- start_cmd outside IDLE is ignored (not queued).
- round_cnt wraps to 0 on entry to IDLE.

Decomposition:
- Shared package (existing parameters include):
  - START_DECODING_MSG
  - MEASUREMENT_DATA_HEADER
  - New sender state encoding localparams (3-bit).
- One natural sub-module: byte_serializer. It holds the buffer, byte_cnt and the valid/ready output stage, with load, last-byte-done and BYTES_PER_ROUND parameterization.

Test Plan:
- X=3,Z=2,U=3: rounds 6'h2D, 6'h00, 6'h3F, tx_ready=1 → bytes HEADER, 8'h2D, 8'h00, 8'h3F; tx_valid low afterwards; busy high throughout.
- X=4,Z=3 (12 PU), round 12'hA5C → bytes 8'h5C then 8'h0A, padding bits zero.
- tx_ready toggling 1-0-0-1 randomly → every byte held stable while stalled; byte count and order identical to the no-stall case.
- start_cmd and round_valid in the same IDLE cycle → START_DECODING_MSG is sent first, then HEADER and the round; the round is accepted only in LOAD_ROUND.
- result_valid 17 cycles after the last transfer → latency=17 with a one-cycle latency_valid; with TIMEOUT_CYCLES=16 and no result → timeout_err=1, state IDLE.
- reset_n pulsed low during the second data byte → tx_valid=0 asynchronously; after release the next round restarts with HEADER.
